// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 mouse receive path.
package ps2_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} frame_state_t;
   typedef enum logic [1:0] {B0, B1, B2} pkt_state_t;

   localparam int B0_LEFT  = 0;
   localparam int B0_RIGHT = 1;
   localparam int B0_SYNC  = 3;
   localparam int B0_XSIGN = 4;
   localparam int B0_YSIGN = 5;
   localparam int B0_XOVF  = 6;
   localparam int B0_YOVF  = 7;

   function automatic logic [11:0] clamp_pos(input logic signed [12:0] v,
                                             input logic [11:0] max_v);
      logic [11:0] r;
      if (v < 13'sd0) begin
         r = 12'd0;
      end else if (v > $signed({1'b0, max_v})) begin
         r = max_v;
      end else begin
         r = v[11:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input sync, clock glitch filter, 11-bit frame FSM and idle timeout.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 65000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       pkt_busy,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       err,
   output logic       tmo
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
   logic          filt_q, filt_d, edge_q, edge_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   frame_state_t  state_q, state_d;
   logic [7:0]    shreg_q, shreg_d, byte_q, byte_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic          par_q, par_d, bv_q, bv_d, err_q, err_d, tmo_q, tmo_d;
   logic          bit_s, busy_s;

   // Next-state logic: filter, timeout and frame FSM.
   always_comb begin
      clk_sync_d = {clk_sync_q[0], ps2_clk};
      dat_sync_d = {dat_sync_q[0], ps2_data};
      filt_d     = filt_q;
      filt_cnt_d = '0;
      edge_d     = 1'b0;
      // A level change must persist FILTER_LEN cycles before it is believed.
      if (clk_sync_q[1] != filt_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q[1];
            edge_d = ~clk_sync_q[1];
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end else begin
         filt_cnt_d = '0;
      end

      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      byte_d    = byte_q;
      bv_d      = 1'b0;
      err_d     = 1'b0;
      tmo_d     = 1'b0;
      bit_s     = dat_sync_q[1];
      busy_s    = (state_q != IDLE) || pkt_busy;

      if (edge_q || !busy_s) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
         tmo_cnt_d = '0;
         tmo_d     = 1'b1;
      end else begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end

      // START means the start bit was seen and the next edge carries D0.
      if (edge_q) begin
         case (state_q)
            IDLE: begin
               if (!bit_s) state_d = START;
               else        err_d   = 1'b1;
            end
            START: begin
               shreg_d   = {bit_s, shreg_q[7:1]};
               bit_cnt_d = 3'd1;
               state_d   = DATA;
            end
            DATA: begin
               shreg_d = {bit_s, shreg_q[7:1]};
               if (bit_cnt_q == 3'd7) state_d   = PARITY;
               else                   bit_cnt_d = bit_cnt_q + 3'd1;
            end
            PARITY: begin
               par_d   = bit_s;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (bit_s && (^{shreg_q, par_q})) begin
                  byte_d = shreg_q;
                  bv_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (tmo_d) begin
         state_d = IDLE;
         err_d   = (state_q != IDLE);
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
         edge_q     <= 1'b0;
         tmo_cnt_q  <= '0;
         state_q    <= IDLE;
         shreg_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         par_q      <= 1'b0;
         byte_q     <= 8'h00;
         bv_q       <= 1'b0;
         err_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
         edge_q     <= edge_d;
         tmo_cnt_q  <= tmo_cnt_d;
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         par_q      <= par_d;
         byte_q     <= byte_d;
         bv_q       <= bv_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
      end
   end

   assign rx_byte    = byte_q;
   assign byte_valid = bv_q;
   assign err        = err_q;
   assign tmo        = tmo_q;

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse decoder: packet assembly and clamped absolute pointer integration.
module ps2_mouse_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 65000,
   parameter int X_MAX       = 1023,
   parameter int Y_MAX       = 767,
   parameter int X_INIT      = 512,
   parameter int Y_INIT      = 384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        left,
   output logic        right,
   output logic        pkt_valid,
   output logic        frame_err
);

   logic [7:0]         rx_byte;
   logic               rx_valid, rx_err, rx_tmo;
   pkt_state_t         pkt_q, pkt_d;
   logic [5:0]         flags_q, flags_d;
   logic [7:0]         b1_q, b1_d;
   logic [11:0]        xpos_q, xpos_d, ypos_q, ypos_d;
   logic               left_q, left_d, right_q, right_d;
   logic               pv_q, pv_d, fe_q, fe_d;
   logic signed [12:0] dx_s, dy_s, xsum_s, ysum_s;

   ps2_frame_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .pkt_busy  (pkt_q != B0),
      .rx_byte   (rx_byte),
      .byte_valid(rx_valid),
      .err       (rx_err),
      .tmo       (rx_tmo)
   );

   // Packet FSM and pointer update; flags_q = {Yovf,Xovf,Ysign,Xsign,R,L}.
   always_comb begin
      pkt_d   = pkt_q;
      flags_d = flags_q;
      b1_d    = b1_q;
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
      left_d  = left_q;
      right_d = right_q;
      pv_d    = 1'b0;
      fe_d    = 1'b0;
      dx_s    = {{5{flags_q[2]}}, b1_q};
      dy_s    = {{5{flags_q[3]}}, rx_byte};
      xsum_s  = $signed({1'b0, xpos_q}) + dx_s;
      ysum_s  = $signed({1'b0, ypos_q}) - dy_s;
      if (rx_err) begin
         fe_d  = 1'b1;
         pkt_d = B0;
      end else if (rx_tmo) begin
         pkt_d = B0;
      end else if (rx_valid) begin
         case (pkt_q)
            B0: begin
               if (rx_byte[B0_SYNC]) begin
                  flags_d = {rx_byte[B0_YOVF], rx_byte[B0_XOVF], rx_byte[B0_YSIGN],
                             rx_byte[B0_XSIGN], rx_byte[B0_RIGHT], rx_byte[B0_LEFT]};
                  pkt_d   = B1;
               end else begin
                  fe_d = 1'b1;
               end
            end
            B1: begin
               b1_d  = rx_byte;
               pkt_d = B2;
            end
            B2: begin
               pkt_d   = B0;
               pv_d    = 1'b1;
               left_d  = flags_q[0];
               right_d = flags_q[1];
               if (!flags_q[4]) xpos_d = clamp_pos(xsum_s, 12'(X_MAX));
               else             xpos_d = xpos_q;
               if (!flags_q[5]) ypos_d = clamp_pos(ysum_s, 12'(Y_MAX));
               else             ypos_d = ypos_q;
            end
            default: pkt_d = B0;
         endcase
      end else begin
         pkt_d = pkt_q;
      end
   end

   // Packet state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_q   <= B0;
         flags_q <= 6'd0;
         b1_q    <= 8'h00;
         xpos_q  <= 12'(X_INIT);
         ypos_q  <= 12'(Y_INIT);
         left_q  <= 1'b0;
         right_q <= 1'b0;
         pv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         pkt_q   <= pkt_d;
         flags_q <= flags_d;
         b1_q    <= b1_d;
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
         left_q  <= left_d;
         right_q <= right_d;
         pv_q    <= pv_d;
         fe_q    <= fe_d;
      end
   end

   assign xpos      = xpos_q;
   assign ypos      = ypos_q;
   assign left      = left_q;
   assign right     = right_q;
   assign pkt_valid = pv_q;
   assign frame_err = fe_q;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Directed bench: drives a PS/2 device model and checks pointer, buttons and pulses.
module tb_ps2_mouse_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [11:0] xpos, ypos;
   logic        left, right, pkt_valid, frame_err;

   int vectors = 0;
   int miscompares = 0;
   int pv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;
   int pv_base, fe_base;

   ps2_mouse_decoder #(.TIMEOUT_CYC(300)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .xpos     (xpos),
      .ypos     (ypos),
      .left     (left),
      .right    (right),
      .pkt_valid(pkt_valid),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pkt_valid) pv_cnt++;
      if (frame_err) fe_cnt++;
      if (pkt_valid && frame_err) both_cnt++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
      ps2_data = 1'b1;
      repeat (40) @(posedge clk);
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0, 1'b0, 11);
      send_byte(b1, 1'b0, 11);
      send_byte(b2, 1'b0, 11);
   endtask

   initial begin
      #2000;
      @(negedge clk);
      chk("reset_xpos", int'(xpos), 512);
      chk("reset_ypos", int'(ypos), 384);
      chk("reset_left", int'(left), 0);
      chk("reset_right", int'(right), 0);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);

      pv_base = pv_cnt;
      send_pkt(8'h08, 8'h10, 8'h00);
      chk("t1_pv", pv_cnt - pv_base, 1);
      chk("t1_xpos", int'(xpos), 528);
      chk("t1_ypos", int'(ypos), 384);
      chk("t1_left", int'(left), 0);

      send_pkt(8'h29, 8'h00, 8'h05);
      chk("t2_ypos", int'(ypos), 635);
      chk("t2_left", int'(left), 1);
      chk("t2_xpos", int'(xpos), 528);
      send_pkt(8'h08, 8'h00, 8'hFB);
      chk("t2b_ypos", int'(ypos), 384);
      chk("t2b_left", int'(left), 0);

      send_pkt(8'h18, 8'hF0, 8'h00);
      chk("t3_back512", int'(xpos), 512);
      for (int i = 0; i < 4; i++) send_pkt(8'h18, 8'h80, 8'h00);
      chk("t3_xmin4", int'(xpos), 0);
      send_pkt(8'h18, 8'h80, 8'h00);
      chk("t3_xmin5", int'(xpos), 0);
      for (int i = 0; i < 4; i++) send_pkt(8'h08, 8'hFF, 8'h00);
      chk("t3_x1020", int'(xpos), 1020);
      send_pkt(8'h08, 8'hFF, 8'h00);
      chk("t3_xmax", int'(xpos), 1023);

      pv_base = pv_cnt;
      fe_base = fe_cnt;
      send_byte(8'h08, 1'b0, 11);
      send_byte(8'h10, 1'b1, 11);
      chk("t4_fe", fe_cnt - fe_base, 1);
      chk("t4_pv", pv_cnt - pv_base, 0);
      chk("t4_xpos", int'(xpos), 1023);
      send_pkt(8'h18, 8'hF6, 8'h00);
      chk("t4_recover", int'(xpos), 1013);
      chk("t4_pv2", pv_cnt - pv_base, 1);

      fe_base = fe_cnt;
      send_byte(8'h00, 1'b0, 11);
      chk("t5_fe", fe_cnt - fe_base, 1);
      send_pkt(8'h08, 8'h01, 8'h01);
      chk("t5_xpos", int'(xpos), 1014);
      chk("t5_ypos", int'(ypos), 383);

      fe_base = fe_cnt;
      send_byte(8'h5A, 1'b0, 5);
      repeat (400) @(posedge clk);
      chk("t6_tmo_fe", fe_cnt - fe_base, 1);
      pv_base = pv_cnt;
      send_pkt(8'h48, 8'h20, 8'h00);
      chk("t6_ovf_pv", pv_cnt - pv_base, 1);
      chk("t6_ovf_x", int'(xpos), 1014);
      chk("t6_ovf_y", int'(ypos), 383);
      send_pkt(8'h0A, 8'h10, 8'h00);
      chk("t6_right", int'(right), 1);
      chk("t6_xclamp", int'(xpos), 1023);

      send_byte(8'h33, 1'b0, 4);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_rst_x", int'(xpos), 512);
      chk("t6_rst_y", int'(ypos), 384);
      chk("t6_rst_r", int'(right), 0);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (20) @(posedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      pv_base = pv_cnt;
      send_pkt(8'h08, 8'h10, 8'h00);
      chk("t6_post_pv", pv_cnt - pv_base, 1);
      chk("t6_post_x", int'(xpos), 528);
      chk("excl_pulses", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
